regfile_write_arbiter: RTL

- Shares the single register-file write port (REG_WR, dirWR, di) of the single-cycle CPU between two writeback sources.
  - Source 0: ALU writeback, normal priority.
  - Source 1: load/memory unit, low priority with starvation guard.
- Presents one registered write per cycle to RegisterFile.
- Diverts writes to R15 (PC) to a separate PC-load strobe, because R15 is driven externally by the fetch logic.
- Flags read-after-write hazards against the write currently in flight.

---
 rtl/regfile_write_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the register-file write port: ALU (source 0) normally wins,
// the load unit (source 1) is forced through after STARVE_MAX lost cycles; R15 writes become a PC-load strobe.
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int PC_ADDR    = 15,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enable,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              REG_WR,
  output logic [ADDR_W-1:0] dirWR,
  output logic [DATA_W-1:0] di,
  output logic              pc_wr,
  output logic [DATA_W-1:0] pc_value,
  output logic              hazard_a,
  output logic              hazard_b
);

  localparam int                CNT_W   = STARVE_MAX;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_ADDR);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  starveCnt;
  logic [CNT_W-1:0]  starveCntNxt;
  logic              force1;
  logic              s0Grant;
  logic              s1Grant;
  logic              vld_p0;
  logic              isPc_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  // Stage p0: combinational arbitration and starvation bookkeeping
  always_comb begin
    force1       = (starveCnt == CNT_MAX) && s1_valid;
    s0_ready     = wr_enable && !force1;
    s1_ready     = wr_enable && (force1 || !s0_valid);
    s0Grant      = s0_valid && s0_ready;
    s1Grant      = s1_valid && s1_ready;
    vld_p0       = s0Grant || s1Grant;
    addr_p0      = s1Grant ? s1_addr : s0_addr;
    data_p0      = s1Grant ? s1_data : s0_data;
    isPc_p0      = (addr_p0 == PC_A);
    starveCntNxt = starveCnt;
    if (wr_enable) begin
      if (!s1_valid || s1Grant) starveCntNxt = '0;
      else                      starveCntNxt = satInc(starveCnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starveCnt <= '0;
    else      starveCnt <= starveCntNxt;
  end

  // Stage p1: registered write port; R15 is owned by fetch, so it goes out as a PC load instead
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      REG_WR   <= 1'b0;
      pc_wr    <= 1'b0;
      dirWR    <= '0;
      di       <= '0;
      pc_value <= '0;
    end else begin
      REG_WR <= vld_p0 && !isPc_p0;
      pc_wr  <= vld_p0 && isPc_p0;
      if (vld_p0 && !isPc_p0) begin
        dirWR <= addr_p0;
        di    <= data_p0;
      end
      if (vld_p0 && isPc_p0) pc_value <= data_p0;
    end
  end

  assign hazard_a = REG_WR && (rd_addr_a == dirWR) && (dirWR != '0);
  assign hazard_b = REG_WR && (rd_addr_b == dirWR) && (dirWR != '0);

endmodule
